// File: rtl/frame_pixel_streamer_if.sv
// Frame-memory read port and pixel stream bundle for frame_pixel_streamer.
// The master side is the streamer. The slave side is the memory plus the downstream line buffer.
interface frame_pixel_streamer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 14
);
  logic                  mem_rd_en;
  logic [ADDR_WIDTH-1:0] mem_rd_addr;
  logic [DATA_WIDTH-1:0] mem_rd_data;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_sof;
  logic                  m_eol;
  logic                  m_eof;

  modport master (
    output mem_rd_en, mem_rd_addr, m_valid, m_data, m_sof, m_eol, m_eof,
    input  mem_rd_data, m_ready
  );

  modport slave (
    input  mem_rd_en, mem_rd_addr, m_valid, m_data, m_sof, m_eol, m_eof,
    output mem_rd_data, m_ready
  );
endinterface

// File: rtl/frame_pixel_streamer.sv
// Raster-scan frame reader: credit-limited memory reads feed a 2-entry skid FIFO,
// which drives a valid/ready pixel stream with sof/eol/eof markers.
//
// state | meaning
// IDLE  | waiting for start; outputs quiet
// RUN   | issuing reads and streaming the frame
module frame_pixel_streamer #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 128,
  parameter int IMG_HEIGHT = 128,
  parameter int ADDR_WIDTH = 14
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic abort,
  output logic busy,
  output logic done,
  frame_pixel_streamer_if.master bus
);

  localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [ADDR_WIDTH:0] N_PIX    = (ADDR_WIDTH+1)'(IMG_WIDTH * IMG_HEIGHT);
  localparam logic [CW-1:0]       COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0]       ROW_LAST = RW'(IMG_HEIGHT - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH:0]   rd_cnt;
  logic                  inflight;
  logic [DATA_WIDTH-1:0] fifo_mem [2];
  logic                  wr_ptr, rd_ptr;
  logic [1:0]            count;
  logic [CW-1:0]         col;
  logic [RW-1:0]         row;

  logic rd_en, done_nxt, start_frame, flush, push, pop, credit, at_eol, at_eof, valid;

  assign valid  = (count != 2'd0);
  assign pop    = valid & bus.m_ready;
  assign flush  = (state == RUN) & abort;
  // Read data arriving in the abort cycle belongs to the cancelled frame.
  assign push   = inflight & (state == RUN) & ~abort;
  assign credit = ({1'b0, count} + {2'b00, inflight}) < (3'd2 + {2'b00, pop});
  assign at_eol = (col == COL_LAST);
  assign at_eof = at_eol & (row == ROW_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= done_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    rd_en       = 1'b0;
    done_nxt    = 1'b0;
    start_frame = 1'b0;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          state_nxt   = RUN;
          start_frame = 1'b1;
        end
      end
      RUN: begin
        if (abort) begin
          state_nxt = IDLE;
        end else begin
          rd_en = (rd_cnt < N_PIX) && credit;
          if (pop && at_eof) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_cnt   <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= rd_en;
      if (start_frame)
        rd_cnt <= '0;
      else if (rd_en)
        rd_cnt <= rd_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      count       <= 2'd0;
    end else if (start_frame || flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= bus.mem_rd_data;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop)
        rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (start_frame || flush) begin
      col <= '0;
      row <= '0;
    end else if (pop) begin
      if (at_eol) begin
        col <= '0;
        row <= at_eof ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  assign bus.mem_rd_en   = rd_en;
  assign bus.mem_rd_addr = rd_cnt[ADDR_WIDTH-1:0];
  assign bus.m_valid     = valid;
  assign bus.m_data      = valid ? fifo_mem[rd_ptr] : '0;
  assign bus.m_sof       = valid & (col == '0) & (row == '0);
  assign bus.m_eol       = valid & at_eol;
  assign bus.m_eof       = valid & at_eof;
  assign busy            = (state == RUN);

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) push |-> (count != 2'd2));

endmodule

// File: doc/frame_pixel_streamer.md
Name: frame_pixel_streamer

Overview:
Raster-scan pixel source for the Sobel pipeline. On a start pulse it reads one IMG_WIDTH x IMG_HEIGHT frame from a synchronous-read frame memory and emits it one pixel per beat on a valid/ready stream. The stream drives the row line buffer's valid_in/din. It also drives frame/line markers. A 2-entry output skid FIFO absorbs the memory read latency under backpressure, so no read data is lost or duplicated.

Parameters:
DATA_WIDTH, 8, pixel width
IMG_WIDTH, 128, pixels per row
IMG_HEIGHT, 128, rows per frame
ADDR_WIDTH, 14, frame memory address width; must satisfy 2^ADDR_WIDTH >= IMG_WIDTH*IMG_HEIGHT

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
start  input  1  frame request pulse; sampled only in IDLE
abort  input  1  synchronous frame cancel
mem_rd_en  output  1  memory read strobe
mem_rd_addr  output  ADDR_WIDTH  read address, row-major, 0 .. W*H-1
mem_rd_data  input  DATA_WIDTH  read data, valid exactly 1 cycle after mem_rd_en
m_valid  output  1  stream beat valid
m_ready  input  1  downstream accept
m_data  output  DATA_WIDTH  pixel
m_sof  output  1  beat is pixel (0,0)
m_eol  output  1  beat is last column of a row
m_eof  output  1  beat is last pixel of frame
busy  output  1  high in RUN
done  output  1  one-cycle pulse at frame completion

Behaviour:
- Reset: state IDLE. All outputs 0. FIFO empty, counters 0, no read in flight.
- FSM IDLE -> RUN:
  - Transition when start=1 and abort=0.
  - Clears rd_addr, out_col, out_row and FIFO on entry.
- RUN -> IDLE after the handshake (m_valid & m_ready) of the beat with m_eof=1.
  - done=1 in the following cycle only.
  - busy drops in that same cycle.
- RUN -> IDLE on abort=1, in any cycle:
  - Next cycle: m_valid=0, FIFO flushed, busy=0, done stays 0.
  - Read data returning after abort is discarded.
- start while in RUN is ignored. abort in IDLE is ignored.
- If start and abort are high together in IDLE, the block stays in IDLE.
- Read issue (combinational mem_rd_en):
  - Condition: state==RUN, abort=0, rd_addr < W*H, and (fifo_count - pop + inflight) < 2.
  - pop = m_valid & m_ready. inflight = mem_rd_en registered by 1 cycle.
  - rd_addr increments on each issue. It never wraps within a frame.
- FIFO:
  - Depth 2. Pushes mem_rd_data in the cycle after an issue.
  - Simultaneous push and pop are allowed.
  - The credit rule guarantees no overflow. A push into a full FIFO is an assertion failure.
- Stream:
  - m_valid = FIFO non-empty. m_data = FIFO head.
  - m_data and markers hold stable while m_valid & !m_ready.
- Markers are derived from output counters out_col/out_row, which advance only on handshake:
  - m_sof = (col==0 && row==0).
  - m_eol = (col==W-1).
  - m_eof = (col==W-1 && row==H-1).
  - col wraps W-1 -> 0 and then row increments.
- Latency: start sampled at edge t0 -> mem_rd_en high during cycle t0..t1 -> m_valid high after edge t2.
- Throughput: 1 beat/cycle sustained with m_ready=1. A frame takes W*H+2 cycles from start to the eof beat.
- Async reset mid-frame returns immediately to reset values. Partial-frame state is not retained.

Test Plan:
- W=4, H=3, memory[i]=i, m_ready=1, start pulse -> m_data 0..11 on consecutive cycles.
  - m_valid first high 2 edges after start.
  - m_sof on beat 0; m_eol on beats 3, 7, 11; m_eof on beat 11.
  - done one cycle after beat 11; exactly 12 mem_rd_en pulses.
- Same frame with m_ready toggled in a 1-high/2-low pattern and random stalls -> identical 0..11 sequence, no drop or duplicate.
  - Data and markers stable during stalls; FIFO count never exceeds 2.
- Abort asserted after beat 5 handshake -> m_valid=0 next cycle, busy=0, no done.
  - Late read data discarded.
  - New start then streams 0..11 with m_sof on the first beat.
- start re-pulsed at beats 2 and 7 during RUN -> ignored; a single 12-beat frame and one done.
- rst_n low mid-frame (beat 6) -> all outputs 0 asynchronously; after release the block sits in IDLE with m_valid=0 until start.
- Back-to-back frames: start in the cycle done is high -> second frame 0..11 begins.
  - Markers are correct, and out_col/out_row restart at 0.
